// File: rtl/axi4_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi4_arb_pkg
//   Shared types and constants for the AXI4 command arbiter.
//   - arb_state_t : arbiter FSM states (IDLE, ISSUE, WAIT)
//   - BURST_*     : AXI burst-type encodings driven on m_burst_type
//   - RW_*        : command direction encodings (0 = write, 1 = read)
// ---------------------------------------------------------------------------
package axi4_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Searches req starting at index
//   ptr and moving upward modulo NUM_REQ; the first set bit wins.
//
//   Ports:
//     req       in  NUM_REQ  request vector
//     ptr       in  IDX_W    search start index (must be < NUM_REQ)
//     grant     out NUM_REQ  one-hot winner (all zero when nothing requests)
//     grant_idx out IDX_W    binary index of the winner (0 when none)
//     found     out 1        at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               found
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // cand_idx[k] is the requester examined at search position k, i.e.
    // (ptr + k) mod NUM_REQ. Works for non-power-of-two NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W)
                                                     : sum[IDX_W-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end back toward position 0 so the closest hit to
    // ptr is the last assignment and therefore wins.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                grant_idx = cand_idx[k];
                found     = 1'b1;
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign grant[gi] = found && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/axi4_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_cmd_arbiter
//   Round-robin arbiter sharing the single command port of axi4_master_fsm
//   between NUM_REQ requesters. One transaction is outstanding at a time:
//   accept a command (IDLE), pulse m_start (ISSUE), then snoop the AXI
//   response channels for completion (WAIT) and pulse done to the owner.
//
//   Optional feature macro: AXI_ARB_TIMEOUT_EN
//     When defined, a watchdog aborts WAIT after TIMEOUT_CYCLES cycles with
//     no completion, pulsing timeout together with done. When undefined,
//     timeout is tied low and WAIT holds until the response arrives.
//
//   Ports:
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     req_valid/ready   per-requester command handshake (ready one-hot/zero)
//     req_addr          flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     req_burst         flattened 2-bit burst types, requester i at [i*2 +: 2]
//     req_rw            per-requester direction (0 write, 1 read)
//     done              one-cycle completion pulse to the granted requester
//     timeout           one-cycle watchdog pulse
//     m_start           one-cycle start pulse to the master
//     m_addr/m_burst_type/m_rw  registered command fields to the master
//     bvalid, bready    snooped write-response handshake
//     rvalid, rready, rlast     snooped read-data handshake
//     busy              high in ISSUE and WAIT
//     grant_id          index of the current or last granted requester
// ---------------------------------------------------------------------------
module axi4_cmd_arbiter
    import axi4_arb_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 32,
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*2-1:0]          req_burst,
    input  logic [NUM_REQ-1:0]            req_rw,
    output logic [NUM_REQ-1:0]            done,
    output logic                          timeout,
    output logic                          m_start,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [1:0]                    m_burst_type,
    output logic                          m_rw,
    input  logic                          bvalid,
    input  logic                          bready,
    input  logic                          rvalid,
    input  logic                          rready,
    input  logic                          rlast,
    output logic                          busy,
    output logic [IDX_W-1:0]              grant_id
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    // -----------------------------------------------------------------
    // State and command registers
    // -----------------------------------------------------------------
    arb_state_t             state_reg,    state_next;
    logic [IDX_W-1:0]       rr_ptr_reg,   rr_ptr_next;
    logic [IDX_W-1:0]       grant_id_reg, grant_id_next;
    logic [ADDR_WIDTH-1:0]  addr_reg,     addr_next;
    logic [1:0]             burst_reg,    burst_next;
    logic                   rw_reg,       rw_next;
    logic [NUM_REQ-1:0]     done_reg,     done_next;

    // -----------------------------------------------------------------
    // Unflattened request fields
    // -----------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  req_addr_arr  [NUM_REQ];
    logic [1:0]             req_burst_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_burst_arr[gi] = req_burst[gi*2 +: 2];
        end
    endgenerate

    // -----------------------------------------------------------------
    // Round-robin pick
    // -----------------------------------------------------------------
    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .found     (pick_found)
    );

    // The picker only grants a requester whose valid is high, so offering
    // ready to the winner while in IDLE is itself the handshake.
    logic accept;
    assign accept    = (state_reg == IDLE) && pick_found;
    assign req_ready = accept ? pick_grant : '0;

    // -----------------------------------------------------------------
    // Completion detection: only the response channel matching the
    // latched direction counts; the other channel is ignored.
    // -----------------------------------------------------------------
    logic rsp_event;
    logic complete;
    logic expire;
    logic finish;

    assign rsp_event = (rw_reg == RW_READ) ? (rvalid & rready & rlast)
                                           : (bvalid & bready);
    assign complete  = (state_reg == WAIT) && rsp_event;
    assign finish    = complete || expire;

    // (grant_id + 1) mod NUM_REQ, so the last winner becomes lowest priority.
    logic [IDX_W:0]   ptr_sum;
    logic [IDX_W-1:0] ptr_after_grant;
    assign ptr_sum         = {1'b0, grant_id_reg} + (IDX_W+1)'(1);
    assign ptr_after_grant = (ptr_sum >= NUM_REQ_W) ? '0 : ptr_sum[IDX_W-1:0];

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_done
            assign done_next[gi] = finish && (grant_id_reg == IDX_W'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------
    // Watchdog
    // -----------------------------------------------------------------
`ifdef AXI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic             timeout_reg, timeout_next;

    // Counter is zero in the first WAIT cycle and counts WAIT cycles. The
    // cycle in which it holds TIMEOUT_CYCLES-1 is the last WAIT cycle; at
    // that edge it reaches TIMEOUT_CYCLES and the watchdog fires. A real
    // completion on the same edge wins and suppresses the timeout flag.
    assign wd_cnt_next  = (state_reg == WAIT) ? wd_cnt_reg + CNT_W'(1) : '0;
    assign expire       = (state_reg == WAIT) && !rsp_event &&
                          (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_next = expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout = timeout_reg;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        addr_next     = addr_reg;
        burst_next    = burst_reg;
        rw_next       = rw_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    grant_id_next = pick_idx;
                    addr_next     = req_addr_arr[pick_idx];
                    burst_next    = req_burst_arr[pick_idx];
                    rw_next       = req_rw[pick_idx];
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (finish) begin
                    rr_ptr_next = ptr_after_grant;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            addr_reg     <= '0;
            burst_reg    <= '0;
            rw_reg       <= 1'b0;
            done_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            addr_reg     <= addr_next;
            burst_reg    <= burst_next;
            rw_reg       <= rw_next;
            done_reg     <= done_next;
        end
    end

    // -----------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------
    assign m_start      = (state_reg == ISSUE);
    assign busy         = (state_reg != IDLE);
    assign m_addr       = addr_reg;
    assign m_burst_type = burst_reg;
    assign m_rw         = rw_reg;
    assign grant_id     = grant_id_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_axi4_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_cmd_arbiter
//   Directed scoreboard bench for axi4_cmd_arbiter (NUM_REQ=4, ADDR_WIDTH=32,
//   TIMEOUT_CYCLES=16). The stimulus thread pushes expected start commands
//   and done pulses into queues; a monitor pops and compares them whenever
//   the DUT raises m_start or done/timeout. The watchdog scenario is built
//   only when AXI_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_axi4_cmd_arbiter;
    import axi4_arb_pkg::*;

    localparam int AW = 32;
    localparam int NR = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*2-1:0] req_burst;
    logic [NR-1:0]   req_rw;
    logic [NR-1:0]   done;
    logic            timeout;
    logic            m_start;
    logic [AW-1:0]   m_addr;
    logic [1:0]      m_burst_type;
    logic            m_rw;
    logic            bvalid, bready, rvalid, rready, rlast;
    logic            busy;
    logic [1:0]      grant_id;

    always #5 clk = ~clk;

    axi4_cmd_arbiter #(
        .ADDR_WIDTH     (AW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_burst    (req_burst),
        .req_rw       (req_rw),
        .done         (done),
        .timeout      (timeout),
        .m_start      (m_start),
        .m_addr       (m_addr),
        .m_burst_type (m_burst_type),
        .m_rw         (m_rw),
        .bvalid       (bvalid),
        .bready       (bready),
        .rvalid       (rvalid),
        .rready       (rready),
        .rlast        (rlast),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    burst;
        logic          rw;
        int            gid;
        int            cyc;
    } start_t;

    typedef struct {
        logic [NR-1:0] vec;
        logic          to;
        int            cyc;
    } done_t;

    start_t start_q[$];
    done_t  done_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h expected no event", name, act);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares every DUT output event against the queues.
    // ------------------------------------------------------------------
    start_t mon_s;
    done_t  mon_d;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m_start) begin
                    if (start_q.size() == 0) begin
                        unexpected("unexpected_start", {32'h0, m_addr});
                    end else begin
                        mon_s = start_q.pop_front();
                        chk("start_cycle", 64'(cyc), 64'(mon_s.cyc));
                        chk("m_addr", 64'(m_addr), 64'(mon_s.addr));
                        chk("m_burst_type", 64'(m_burst_type), 64'(mon_s.burst));
                        chk("m_rw", 64'(m_rw), 64'(mon_s.rw));
                        chk("grant_id", 64'(grant_id), 64'(mon_s.gid));
                        $display("start  cyc=%0d grant=%0d addr=%h burst=%b rw=%b",
                                 cyc, grant_id, m_addr, m_burst_type, m_rw);
                    end
                end
                if (done != '0 || timeout) begin
                    if (done_q.size() == 0) begin
                        unexpected("unexpected_done", {59'h0, timeout, done});
                    end else begin
                        mon_d = done_q.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(mon_d.cyc));
                        chk("done_vec", 64'(done), 64'(mon_d.vec));
                        chk("timeout", 64'(timeout), 64'(mon_d.to));
                        $display("done   cyc=%0d vec=%b timeout=%b", cyc, done, timeout);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end at a falling edge)
    // ------------------------------------------------------------------
    task automatic set_req(input int i, input logic [AW-1:0] a,
                           input logic [1:0] b, input logic rw);
        req_addr[i*AW +: AW] = a;
        req_burst[i*2 +: 2]  = b;
        req_rw[i]            = rw;
    endtask

    // Wait for the arbiter to offer ready, check it goes to requester w and
    // queue the start command expected one cycle after the accept edge.
    // Returns at the falling edge of the ISSUE cycle.
    task automatic arbitrate(input int w);
        int     n;
        start_t s;
        logic [NR-1:0] exp_vec;
        n = 0;
        #1;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_ready == '0) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: got no req_ready expected grant to %0d", w);
        end else begin
            exp_vec = NR'(1) << w;
            chk($sformatf("req_ready_w%0d", w), 64'(req_ready), 64'(exp_vec));
            s.addr  = req_addr[w*AW +: AW];
            s.burst = req_burst[w*2 +: 2];
            s.rw    = req_rw[w];
            s.gid   = w;
            s.cyc   = cyc + 1;
            start_q.push_back(s);
        end
        @(negedge clk);
    endtask

    task automatic expect_done(input int w, input logic to, input int at_cyc);
        done_t d;
        d.vec = NR'(1) << w;
        d.to  = to;
        d.cyc = at_cyc;
        done_q.push_back(d);
    endtask

    task automatic complete_write(input int w);
        bvalid = 1'b1;
        bready = 1'b1;
        expect_done(w, 1'b0, cyc + 1);
        @(negedge clk);
        bvalid = 1'b0;
        bready = 1'b0;
    endtask

    task automatic complete_read(input int w);
        rvalid = 1'b1;
        rready = 1'b1;
        rlast  = 1'b1;
        expect_done(w, 1'b0, cyc + 1);
        @(negedge clk);
        rvalid = 1'b0;
        rready = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic rbeat(input logic rv, input logic rr, input logic rl);
        rvalid = rv;
        rready = rr;
        rlast  = rl;
        @(negedge clk);
        rvalid = 1'b0;
        rready = 1'b0;
        rlast  = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        req_valid = '0;
        req_addr  = '0;
        req_burst = '0;
        req_rw    = '0;
        bvalid = 1'b0; bready = 1'b0;
        rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_start", 64'(m_start), 64'(0));
        chk("rst_m_addr", 64'(m_addr), 64'(0));
        chk("rst_m_burst", 64'(m_burst_type), 64'(0));
        chk("rst_m_rw", 64'(m_rw), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_timeout", 64'(timeout), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: all four hold valid, grants rotate 0,1,2,3,0
        for (int i = 0; i < NR; i++)
            set_req(i, 32'h0000_0100 * (i + 1), BURST_INCR, RW_WRITE);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            arbitrate(ord[k]);
            repeat (1 + (k % 3)) @(negedge clk);
            complete_write(ord[k]);
        end
        req_valid = '0;
        @(negedge clk);

        // Single write from requester 0; stray B during ISSUE is ignored
        set_req(0, 32'h0000_1000, BURST_INCR, RW_WRITE);
        req_valid = 4'b0001;
        arbitrate(0);
        req_valid = '0;
        bvalid = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        bready = 1'b0;
        repeat (2) @(negedge clk);
        complete_write(0);

        // Single read from requester 2; non-last beats give no done
        set_req(2, 32'h0000_2000, BURST_INCR, RW_READ);
        req_valid = 4'b0100;
        arbitrate(2);
        req_valid = '0;
        @(negedge clk);
        chk("busy_in_wait", 64'(busy), 64'(1));
        repeat (3) rbeat(1'b1, 1'b1, 1'b0);
        complete_read(2);
        chk("busy_after_read", 64'(busy), 64'(0));

        // Direction filter: write response and unaccepted rlast during a read
        set_req(1, 32'h0000_3040, BURST_WRAP, RW_READ);
        req_valid = 4'b0010;
        arbitrate(1);
        req_valid = '0;
        @(negedge clk);
        bvalid = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        bready = 1'b0;
        rbeat(1'b1, 1'b0, 1'b1);
        complete_read(1);

        // Reset in the middle of WAIT; round-robin pointer returns to 0
        set_req(2, 32'h0000_4000, BURST_FIXED, RW_WRITE);
        req_valid = 4'b0100;
        arbitrate(2);
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_m_start", 64'(m_start), 64'(0));
        chk("midrst_m_addr", 64'(m_addr), 64'(0));
        chk("midrst_m_burst", 64'(m_burst_type), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_grant_id", 64'(grant_id), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_req(1, 32'h0000_5000, BURST_INCR, RW_WRITE);
        set_req(3, 32'h0000_6000, BURST_INCR, RW_WRITE);
        req_valid = 4'b1010;
        arbitrate(1);
        req_valid = '0;
        @(negedge clk);
        complete_write(1);

`ifdef AXI_ARB_TIMEOUT_EN
        // Watchdog: no response, timeout + done 16 cycles after WAIT entry
        begin
            int n;
            set_req(2, 32'h0000_7000, BURST_INCR, RW_WRITE);
            req_valid = 4'b0100;
            arbitrate(2);
            req_valid = '0;
            // Now in the ISSUE cycle; WAIT starts next cycle.
            expect_done(2, 1'b1, cyc + 1 + TO);
            n = 0;
            while (done == '0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (done == '0) begin
                checks++;
                errors++;
                $display("FAIL timeout_wait: got no done expected watchdog pulse");
            end
            set_req(3, 32'h0000_8000, BURST_INCR, RW_WRITE);
            req_valid = 4'b1100;
            arbitrate(3);
            req_valid = '0;
            @(negedge clk);
            complete_write(3);
        end
`endif

        repeat (5) @(negedge clk);
        chk("start_q_drained", 64'(start_q.size()), 64'(0));
        chk("done_q_drained", 64'(done_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

endmodule
